// File: rtl/mc14500_pkg.sv
// Shared MC14500B definitions: ICU opcodes and program-word field helpers.
package mc14500_pkg;

  localparam int OPC_W      = 4;
  localparam int MAX_ADDR_W = 32;

  typedef enum logic [OPC_W-1:0] {
    NOPO = 4'h0,
    LD   = 4'h1,
    LDC  = 4'h2,
    AND  = 4'h3,
    ANDC = 4'h4,
    OR   = 4'h5,
    ORC  = 4'h6,
    XNOR = 4'h7,
    STO  = 4'h8,
    STOC = 4'h9,
    IEN  = 4'hA,
    OEN  = 4'hB,
    JMP  = 4'hC,
    RTN  = 4'hD,
    SKZ  = 4'hE,
    NOPF = 4'hF
  } instruction_t;

  // Words are zero-extended to the widest supported operand before splitting.
  function automatic instruction_t word_opcode(
    input logic [OPC_W+MAX_ADDR_W-1:0] w,
    input int                          aw
  );
    return instruction_t'(OPC_W'(w >> aw));
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] word_operand(
    input logic [OPC_W+MAX_ADDR_W-1:0] w,
    input int                          aw
  );
    return MAX_ADDR_W'(w) & ~({MAX_ADDR_W{1'b1}} << aw);
  endfunction

endpackage

// File: rtl/mc14500_sequencer_if.sv
// ROM fetch and ICU issue bus between the sequencer and its surroundings.
interface mc14500_sequencer_if
  import mc14500_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0]       rom_addr;
  logic [OPC_W+ADDR_W-1:0] rom_data;
  instruction_t            icu_instr;
  logic [ADDR_W-1:0]       io_addr;
  logic                    bubble;

  modport master (
    output rom_addr,
    output icu_instr,
    output io_addr,
    output bubble,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    input  icu_instr,
    input  io_addr,
    input  bubble,
    output rom_data
  );
endinterface

// File: rtl/mc14500_ret_stack.sv
// Registered LIFO of return addresses; push and pop never coincide.
module mc14500_ret_stack #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          din,
  output logic [ADDR_W-1:0]          dout,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       full,
  output logic                       empty
);
  localparam int SPW = $clog2(DEPTH+1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] mem [2**IW];
  logic [IW-1:0]     top_i;
  logic [IW-1:0]     wr_i;

  assign top_i = IW'(sp - 1'b1);
  assign wr_i  = IW'(sp);
  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);
  assign dout  = mem[top_i];

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_i] <= din;
    end
  end

endmodule

// File: rtl/mc14500_sequencer.sv
// MC14500B program sequencer: PC, ROM fetch, JMP/RTN call stack, bubbles.
// Define MC14500_SEQ_HALT_ON_NOPF_EN to halt (until reset) after an issued NOPF.
module mc14500_sequencer
  import mc14500_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  mc14500_sequencer_if.master        bus,
  output logic [$clog2(DEPTH+1)-1:0] sp,
  output logic                       err_ovf,
  output logic                       err_unf
`ifdef MC14500_SEQ_HALT_ON_NOPF_EN
  ,
  output logic                       halted
`endif
);

  logic [ADDR_W-1:0]             pc;
  logic [ADDR_W-1:0]             pc_n;
  logic [ADDR_W-1:0]             fetch_pc;
  logic [ADDR_W-1:0]             opr;
  logic [ADDR_W-1:0]             dout;
  logic [OPC_W+MAX_ADDR_W-1:0]   word;
  instruction_t                  opc;
  logic slot_valid;
  logic sv_n;
  logic issue;
  logic push;
  logic pop;
  logic full;
  logic empty;
  logic ovf_set;
  logic unf_set;
  logic halt_q;

`ifdef MC14500_SEQ_HALT_ON_NOPF_EN
  logic halt_n;

  assign halted = halt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_n;
    end
  end
`else
  assign halt_q = 1'b0;
`endif

  assign word  = (OPC_W+MAX_ADDR_W)'(bus.rom_data);
  assign opc   = word_opcode(word, ADDR_W);
  assign opr   = ADDR_W'(word_operand(word, ADDR_W));
  assign issue = slot_valid && en && !halt_q;

  assign bus.rom_addr  = pc;
  assign bus.icu_instr = issue ? opc : NOPO;
  assign bus.io_addr   = issue ? opr : '0;
  assign bus.bubble    = !issue;

  always_comb begin
    pc_n    = pc + 1'b1;
    sv_n    = 1'b1;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
`ifdef MC14500_SEQ_HALT_ON_NOPF_EN
    halt_n  = halt_q;
`endif
    if (halt_q) begin
      pc_n = pc;
      sv_n = 1'b0;
    end else if (!en) begin
      // The presented word is dropped and fetched again.
      pc_n = slot_valid ? fetch_pc : pc;
      sv_n = 1'b0;
    end else if (issue && opc == JMP) begin
      push    = !full;
      ovf_set = full;
      pc_n    = opr;
      sv_n    = 1'b0;
    end else if (issue && opc == RTN) begin
      pop     = !empty;
      unf_set = empty;
      pc_n    = empty ? '0 : dout;
      sv_n    = 1'b0;
`ifdef MC14500_SEQ_HALT_ON_NOPF_EN
    end else if (issue && opc == NOPF) begin
      halt_n = 1'b1;
      pc_n   = pc;
      sv_n   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc         <= '0;
      fetch_pc   <= '0;
      slot_valid <= 1'b0;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
    end else begin
      pc         <= pc_n;
      slot_valid <= sv_n;
      if (!halt_q) begin
        fetch_pc <= pc;
      end
      if (ovf_set) begin
        err_ovf <= 1'b1;
      end
      if (unf_set) begin
        err_unf <= 1'b1;
      end
    end
  end

  mc14500_ret_stack #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (fetch_pc + 1'b1),
    .dout  (dout),
    .sp    (sp),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Directed bench for mc14500_sequencer with a 1-cycle synchronous ROM model.
module tb_mc14500_sequencer;
  import mc14500_pkg::*;

  localparam int AW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] sp;
  logic       err_ovf;
  logic       err_unf;
`ifdef MC14500_SEQ_HALT_ON_NOPF_EN
  logic       halted;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [OPC_W+AW-1:0] rom [256];

  mc14500_sequencer_if #(.ADDR_W(AW)) bus ();

  mc14500_sequencer #(
    .ADDR_W (AW),
    .DEPTH  (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bus     (bus),
    .sp      (sp),
    .err_ovf (err_ovf),
    .err_unf (err_unf)
`ifdef MC14500_SEQ_HALT_ON_NOPF_EN
    ,
    .halted  (halted)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  function automatic logic [OPC_W+AW-1:0] mk(
    input instruction_t o,
    input logic [AW-1:0] a
  );
    return {o, a};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic load_default();
    for (int i = 0; i < 256; i++) rom[i] = mk(LD, AW'(i));
  endtask

  task automatic cyc(input logic e);
    @(negedge clk);
    en = e;
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst.addr", 32'(bus.rom_addr), 0);
    chk("rst.bub", 32'(bus.bubble), 1);
    chk("rst.op", 32'(bus.icu_instr), 32'(NOPO));
    chk("rst.io", 32'(bus.io_addr), 0);
    chk("rst.sp", 32'(sp), 0);
    chk("rst.err", 32'({err_ovf, err_unf}), 0);
  endtask

  task automatic exp_issue(
    input string         tag,
    input instruction_t  o,
    input logic [AW-1:0] a
  );
    cyc(1'b1);
    chk({tag, ".op"}, 32'(bus.icu_instr), 32'(o));
    chk({tag, ".io"}, 32'(bus.io_addr), 32'(a));
    chk({tag, ".bub"}, 32'(bus.bubble), 0);
  endtask

  task automatic exp_bub(input string tag, input logic e);
    cyc(e);
    chk({tag, ".bub"}, 32'(bus.bubble), 1);
    chk({tag, ".op"}, 32'(bus.icu_instr), 32'(NOPO));
    chk({tag, ".io"}, 32'(bus.io_addr), 0);
  endtask

  initial begin
    // Linear code after reset
    load_default();
    rom[0] = mk(LD, 8'h03);
    rom[1] = mk(OR, 8'h04);
    rom[2] = mk(STO, 8'h05);
    reset_dut();
    exp_issue("lin1", LD, 8'h03);
    exp_issue("lin2", OR, 8'h04);
    exp_issue("lin3", STO, 8'h05);
    exp_issue("lin4", LD, 8'h03);
    chk("lin4.addr", 32'(bus.rom_addr), 32'h04);

    // Call and return
    load_default();
    rom[8'h00] = mk(JMP, 8'h10);
    rom[8'h01] = mk(OEN, 8'h01);
    rom[8'h10] = mk(LD, 8'h02);
    rom[8'h11] = mk(RTN, 8'h00);
    reset_dut();
    exp_issue("call1", JMP, 8'h10);
    chk("call1.sp", 32'(sp), 0);
    exp_bub("call2", 1'b1);
    chk("call2.sp", 32'(sp), 1);
    exp_issue("call3", LD, 8'h02);
    exp_issue("call4", RTN, 8'h00);
    exp_bub("call5", 1'b1);
    chk("call5.sp", 32'(sp), 0);
    chk("call5.addr", 32'(bus.rom_addr), 32'h01);
    exp_issue("call6", OEN, 8'h01);
    exp_issue("call7", LD, 8'h02);

    // Overflow: third nested call drops its return address
    load_default();
    rom[8'h00] = mk(JMP, 8'h20);
    rom[8'h20] = mk(JMP, 8'h30);
    rom[8'h30] = mk(JMP, 8'h40);
    rom[8'h40] = mk(RTN, 8'h00);
    reset_dut();
    exp_issue("ovf1", JMP, 8'h20);
    exp_bub("ovf2", 1'b1);
    chk("ovf2.sp", 32'(sp), 1);
    exp_issue("ovf3", JMP, 8'h30);
    exp_bub("ovf4", 1'b1);
    chk("ovf4.sp", 32'(sp), 2);
    chk("ovf4.err", 32'(err_ovf), 0);
    exp_issue("ovf5", JMP, 8'h40);
    exp_bub("ovf6", 1'b1);
    chk("ovf6.sp", 32'(sp), 2);
    chk("ovf6.err", 32'(err_ovf), 1);
    chk("ovf6.addr", 32'(bus.rom_addr), 32'h40);
    exp_issue("ovf7", RTN, 8'h00);
    exp_bub("ovf8", 1'b1);
    chk("ovf8.sp", 32'(sp), 1);
    exp_issue("ovf9", LD, 8'h21);
    chk("ovf9.unf", 32'(err_unf), 0);

    // Underflow: return with an empty stack restarts at 0
    load_default();
    rom[0] = mk(RTN, 8'h00);
    reset_dut();
    exp_issue("unf1", RTN, 8'h00);
    exp_bub("unf2", 1'b1);
    chk("unf2.err", 32'(err_unf), 1);
    chk("unf2.sp", 32'(sp), 0);
    chk("unf2.addr", 32'(bus.rom_addr), 0);
    exp_issue("unf3", RTN, 8'h00);

    // Stall while word 0x05 is presented
    load_default();
    reset_dut();
    for (int i = 0; i < 5; i++) exp_issue("run", LD, AW'(i));
    exp_bub("stl1", 1'b0);
    exp_bub("stl2", 1'b0);
    exp_bub("stl3", 1'b0);
    exp_bub("stl4", 1'b1);
    chk("stl4.addr", 32'(bus.rom_addr), 32'h05);
    exp_issue("stl5", LD, 8'h05);
    exp_issue("stl6", LD, 8'h06);

    // PC wrap at the top of the address space
    load_default();
    rom[0] = mk(JMP, 8'hFE);
    reset_dut();
    exp_issue("wrp1", JMP, 8'hFE);
    exp_bub("wrp2", 1'b1);
    exp_issue("wrp3", LD, 8'hFE);
    chk("wrp3.addr", 32'(bus.rom_addr), 32'hFF);
    exp_issue("wrp4", LD, 8'hFF);
    chk("wrp4.addr", 32'(bus.rom_addr), 0);
    exp_issue("wrp5", JMP, 8'hFE);
    chk("wrp5.err", 32'({err_ovf, err_unf}), 0);

`ifdef MC14500_SEQ_HALT_ON_NOPF_EN
    // Halt on NOPF, cleared by reset
    load_default();
    rom[3] = mk(NOPF, 8'h00);
    reset_dut();
    chk("hlt0", 32'(halted), 0);
    for (int i = 0; i < 3; i++) exp_issue("hrun", LD, AW'(i));
    exp_issue("hlt1", NOPF, 8'h00);
    chk("hlt1.h", 32'(halted), 0);
    exp_bub("hlt2", 1'b1);
    chk("hlt2.h", 32'(halted), 1);
    exp_bub("hlt3", 1'b0);
    exp_bub("hlt4", 1'b1);
    reset_dut();
    chk("hlt5.h", 32'(halted), 0);
    exp_issue("hlt6", LD, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
